// File: rtl/arbiter_pred_pkg.sv
// arbiter_pred_pkg
// Shared types for the arbiter: how a held grant is released.
// Ports: none (package).
package arbiter_pred_pkg;

  typedef enum logic [1:0] {
    HOLD_NONE = 2'd0,  // re-arbitrate every cycle
    HOLD_ACK  = 2'd1,  // grant held until its acknowledge bit is seen
    HOLD_REQ  = 2'd2   // grant held while the granted request stays high
  } hold_mode_e;

  function automatic hold_mode_e hold_mode(input int block, input int block_ack);
    if (block == 0) return HOLD_NONE;
    return (block_ack != 0) ? HOLD_ACK : HOLD_REQ;
  endfunction

endpackage

// File: rtl/arbiter_pred_priority_encoder.sv
// priority_encoder
// Picks the highest-priority set bit of a vector.
// Ports:
//   input_unencoded  : candidate bits
//   output_valid     : any bit set
//   output_encoded   : index of the winning bit (0 when none)
//   output_unencoded : one-hot of the winning bit (0 when none)
module priority_encoder #(
  parameter int WIDTH             = 4,
  parameter int LSB_HIGH_PRIORITY = 0
) (
  input  logic [WIDTH-1:0]         input_unencoded,
  output logic                     output_valid,
  output logic [$clog2(WIDTH)-1:0] output_encoded,
  output logic [WIDTH-1:0]         output_unencoded
);

  localparam int IDX_W = $clog2(WIDTH);

  assign output_valid = |input_unencoded;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    output_encoded = '0;
    if (LSB_HIGH_PRIORITY != 0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (input_unencoded[i]) output_encoded = i[IDX_W-1:0];
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (input_unencoded[i]) output_encoded = i[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    output_unencoded = '0;
    if (output_valid) output_unencoded[output_encoded] = 1'b1;
  end

endmodule

// File: rtl/arbiter_pred.sv
// arbiter_pred
// Registered N-way arbiter: fixed priority or round-robin, with optional
// grant holding released either by acknowledge or by the request dropping.
// Ports:
//   clk           : clock, rising edge
//   rst           : asynchronous reset, active low
//   request       : per-port request
//   acknowledge   : per-port release of a held grant (bits off-grant ignored)
//   grant         : one-hot grant or zero (registered)
//   grant_valid   : OR of grant (registered)
//   grant_encoded : index of the granted port, 0 when idle (registered)
module arbiter_pred
  import arbiter_pred_pkg::*;
#(
  parameter int PORTS                 = 4,
  parameter int ARB_TYPE_ROUND_ROBIN  = 0,
  parameter int ARB_BLOCK             = 0,
  parameter int ARB_BLOCK_ACK         = 1,
  parameter int ARB_LSB_HIGH_PRIORITY = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PORTS-1:0]         request,
  input  logic [PORTS-1:0]         acknowledge,
  output logic [PORTS-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(PORTS)-1:0] grant_encoded
);

  localparam int         IDX_W = $clog2(PORTS);
  localparam hold_mode_e HOLD  = hold_mode(ARB_BLOCK, ARB_BLOCK_ACK);

  logic [PORTS-1:0] grant_p0, grant_d;
  logic [PORTS-1:0] mask_p0, mask_d;
  logic             vld_p0, vld_d;
  logic [IDX_W-1:0] enc_p0, enc_d;

  logic             req_vld, msk_vld;
  logic [IDX_W-1:0] req_enc, msk_enc;
  logic [PORTS-1:0] req_onehot, msk_onehot;
  logic [PORTS-1:0] masked_req;
  logic             hold;

  assign masked_req = request & mask_p0;

  priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
  ) u_enc_req (
    .input_unencoded  (request),
    .output_valid     (req_vld),
    .output_encoded   (req_enc),
    .output_unencoded (req_onehot)
  );

  priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
  ) u_enc_masked (
    .input_unencoded  (masked_req),
    .output_valid     (msk_vld),
    .output_encoded   (msk_enc),
    .output_unencoded (msk_onehot)
  );

  always_comb begin
    hold = 1'b0;
    case (HOLD)
      HOLD_ACK: hold = vld_p0 && ((grant_p0 & acknowledge) == '0);
      HOLD_REQ: hold = (grant_p0 & request) != '0;
      default:  hold = 1'b0;
    endcase
  end

  always_comb begin
    grant_d = grant_p0;
    vld_d   = vld_p0;
    enc_d   = enc_p0;
    mask_d  = mask_p0;
    if (!hold) begin
      // An empty masked set means the rotation wrapped: fall back to the
      // plain request so the top-priority requester is served next.
      if ((ARB_TYPE_ROUND_ROBIN != 0) && msk_vld) begin
        grant_d = msk_onehot;
        enc_d   = msk_enc;
      end else begin
        grant_d = req_onehot;
        enc_d   = req_enc;
      end
      vld_d = req_vld;
      // Only ports strictly behind the winner in priority order stay eligible.
      if ((ARB_TYPE_ROUND_ROBIN != 0) && req_vld) begin
        for (int i = 0; i < PORTS; i++) begin
          mask_d[i] = (ARB_LSB_HIGH_PRIORITY != 0) ? (i > int'(enc_d)) : (i < int'(enc_d));
        end
      end
    end
  end

  // ---- stage p0: registered grant state ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_p0 <= '0;
      vld_p0   <= 1'b0;
      enc_p0   <= '0;
      mask_p0  <= '1;
    end else begin
      grant_p0 <= grant_d;
      vld_p0   <= vld_d;
      enc_p0   <= enc_d;
      mask_p0  <= mask_d;
    end
  end

  assign grant         = grant_p0;
  assign grant_valid   = vld_p0;
  assign grant_encoded = enc_p0;

endmodule

// File: tb/tb_arbiter_pred.sv
// tb_arbiter_pred
// Drives four arbiter configurations (PORTS=4) from shared request and
// acknowledge stimulus and compares each against a behavioural model that
// tracks the granted index and the last served port.
//   0: fixed priority, LSB high, no hold
//   1: fixed priority, MSB high, no hold
//   2: round-robin,    LSB high, hold until acknowledge
//   3: round-robin,    MSB high, hold while request stays high
module tb_arbiter_pred;

  localparam int N  = 4;
  localparam int NC = 4;
  localparam logic [NC-1:0] RR_V   = 4'b1100;
  localparam logic [NC-1:0] LSB_V  = 4'b0101;
  localparam logic [NC-1:0] BLK_V  = 4'b1100;
  localparam logic [NC-1:0] BACK_V = 4'b0111;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] request = '0;
  logic [N-1:0] acknowledge = '0;
  logic [N-1:0] gnt [NC];
  logic         vld [NC];
  logic [1:0]   enc [NC];

  int total = 0;
  int bad   = 0;
  int m_idx  [NC];
  int m_last [NC];

  always #5 clk = ~clk;

  arbiter_pred #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0),
                 .ARB_BLOCK_ACK(1), .ARB_LSB_HIGH_PRIORITY(1)) u_fp_lsb (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(gnt[0]), .grant_valid(vld[0]), .grant_encoded(enc[0]));

  arbiter_pred #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0),
                 .ARB_BLOCK_ACK(1), .ARB_LSB_HIGH_PRIORITY(0)) u_fp_msb (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(gnt[1]), .grant_valid(vld[1]), .grant_encoded(enc[1]));

  arbiter_pred #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1),
                 .ARB_BLOCK_ACK(1), .ARB_LSB_HIGH_PRIORITY(1)) u_rr_lsb_ack (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(gnt[2]), .grant_valid(vld[2]), .grant_encoded(enc[2]));

  arbiter_pred #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1),
                 .ARB_BLOCK_ACK(0), .ARB_LSB_HIGH_PRIORITY(0)) u_rr_msb_req (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(gnt[3]), .grant_valid(vld[3]), .grant_encoded(enc[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] m_grant(input int c);
    logic [N-1:0] g;
    g = '0;
    if (m_idx[c] >= 0) g[m_idx[c]] = 1'b1;
    return g;
  endfunction

  function automatic bit eligible(input int c, input int i);
    if (!RR_V[c] || m_last[c] < 0) return 1'b1;
    return LSB_V[c] ? (i > m_last[c]) : (i < m_last[c]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_idx[c]  = -1;
      m_last[c] = -1;
    end
  endtask

  // Next state of configuration c given the inputs seen at the coming edge.
  task automatic model_step(input int c, input logic [N-1:0] rq, input logic [N-1:0] ak);
    bit hold;
    int best;
    hold = 1'b0;
    if (BLK_V[c] && m_idx[c] >= 0)
      hold = BACK_V[c] ? !ak[m_idx[c]] : rq[m_idx[c]];
    if (hold) return;
    best = -1;
    for (int r = 0; r < N; r++) begin
      int i;
      i = LSB_V[c] ? r : N - 1 - r;
      if (best < 0 && rq[i] && eligible(c, i)) best = i;
    end
    for (int r = 0; r < N; r++) begin
      int i;
      i = LSB_V[c] ? r : N - 1 - r;
      if (best < 0 && rq[i]) best = i;
    end
    m_idx[c] = best;
    if (RR_V[c] && best >= 0) m_last[c] = best;
  endtask

  task automatic check_all();
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("grant%0d", c), {28'd0, gnt[c]}, {28'd0, m_grant(c)});
      chk($sformatf("valid%0d", c), {31'd0, vld[c]}, (m_idx[c] >= 0) ? 32'd1 : 32'd0);
      chk($sformatf("enc%0d", c), {30'd0, enc[c]}, (m_idx[c] >= 0) ? m_idx[c] : 0);
    end
  endtask

  task automatic cycle(input logic [N-1:0] rq, input logic [N-1:0] ak);
    request     = rq;
    acknowledge = ak;
    for (int c = 0; c < NC; c++) model_step(c, rq, ak);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Reset asserted between edges must clear outputs without waiting for clk.
  task automatic mid_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [N-1:0] rr_seq [7];
    logic [N-1:0] rq, ak;
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

    model_reset();
    #12;
    check_all();
    rst = 1'b1;

    // Fixed priority, both orders
    cycle(4'b0110, 4'b0000);
    chk("fp_lsb_gnt", {28'd0, gnt[0]}, 32'h2);
    chk("fp_lsb_enc", {30'd0, enc[0]}, 32'd1);
    chk("fp_lsb_vld", {31'd0, vld[0]}, 32'd1);
    chk("fp_msb_gnt", {28'd0, gnt[1]}, 32'h4);
    chk("fp_msb_enc", {30'd0, enc[1]}, 32'd2);

    // Idle after acknowledge with no requests
    cycle(4'b0000, m_grant(2));
    chk("idle_vld", {31'd0, vld[2]}, 32'd0);

    // Hold until acknowledge
    mid_reset();
    cycle(4'b0001, 4'b0000);
    chk("blk_first", {28'd0, gnt[2]}, 32'h1);
    cycle(4'b1000, 4'b0000);
    chk("blk_hold", {28'd0, gnt[2]}, 32'h1);
    cycle(4'b1000, 4'b0001);
    chk("blk_release", {28'd0, gnt[2]}, 32'h8);

    // Round-robin rotation with zero-bubble acknowledge
    mid_reset();
    for (int k = 0; k < 7; k++) begin
      cycle(4'b1111, m_grant(2));
      chk($sformatf("rr_seq%0d", k), {28'd0, gnt[2]}, {28'd0, rr_seq[k]});
    end

    // Reset mid-operation, then rotation restarts from the top
    mid_reset();
    chk("rst_gnt", {28'd0, gnt[2]}, 32'h0);
    chk("rst_vld", {31'd0, vld[2]}, 32'd0);
    chk("rst_enc", {30'd0, enc[2]}, 32'd0);
    cycle(4'b1111, 4'b0000);
    chk("rst_restart", {28'd0, gnt[2]}, 32'h1);

    // Randomized traffic
    rq = '0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) != 0) rq = 4'($urandom);
      ak = 4'($urandom);
      if ($urandom_range(0, 1) == 1) ak = ak | m_grant(2);
      cycle(rq, ak);
      if ($urandom_range(0, 79) == 0) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
